mac_sequencer: RTL and testbench
================================

MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 The block SHALL have parameter LEN_WIDTH, default 8, giving the width of the dot-product length.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 Port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-004 Port rst_in, input, 1: synchronous active-high reset.
REQ-005 Port start, input, 1: request a new dot product; sampled only in IDLE.
REQ-006 Port len, input, LEN_WIDTH: number of products; latched on an accepted start.
REQ-007 Port op_valid, input, 1: upstream operand pair (a, b) is present at the MAC inputs.
REQ-008 Port op_ready, output, 1: sequencer accepts the operand pair this cycle.
REQ-009 Port mac_p_valid, output, 1: drives the MAC p_valid (load the product register).
REQ-010 Port mac_input_valid, output, 1: drives the MAC input_valid (write the accumulator).
REQ-011 Port mac_accumulate, output, 1: drives the MAC accumulate_internal.
REQ-012 Port result_valid, output, 1: the MAC out port holds the final sum.
REQ-013 Port result_ready, input, 1: downstream takes the result.
REQ-014 Port busy, output, 1: high whenever the state is not IDLE.
REQ-015 Port len_err, output, 1: one-cycle pulse on a rejected start.
REQ-016 Port abort, input, 1: present only when MAC_SEQ_ABORT_EN is defined.

Function
REQ-017 States SHALL be IDLE, RUN and LAST.
REQ-018 IDLE: the block SHALL hold op_ready=0 and result_valid=0.
- start=1 and len>0: latch len, clear the accept counter and the pending flag, go to RUN.
- start=1 and len=0: pulse len_err for 1 cycle and stay in IDLE.
REQ-019 RUN: op_ready SHALL be 1.
- Accept = op_valid & op_ready; accept drives mac_p_valid=1 in the same cycle and increments the accept counter.
REQ-020 The pending flag SHALL be set by an accept and cleared by a consume.
- Pending=1 means the product register holds an unconsumed product.
REQ-021 Every cycle with pending=1 in RUN SHALL consume the product.
- Drive mac_input_valid=1.
- mac_accumulate=0 for product index 0; mac_accumulate=1 for every later index.
REQ-022 The accept and consume of consecutive products MAY occur in the same cycle.
- The accumulator takes the old product; the product register takes the new one.
REQ-023 Bubbles (op_valid=0) SHALL only delay the operation and SHALL NOT alter the result.
REQ-024 On accepting the product with index len-1, the block SHALL go to LAST.
REQ-025 LAST: the block SHALL drive op_ready=0, mac_p_valid=0, mac_input_valid=0, mac_accumulate=(len>1) and result_valid=1.
- The MAC out then equals the full sum, through its combinational sum path.
REQ-026 result_valid SHALL stay high, with all MAC controls frozen, until result_ready=1; the block then returns to IDLE.
REQ-027 The latency from the last accept to the first result_valid SHALL be 1 cycle.
- For len=N with no bubbles and result_ready held 1: start-accept to IDLE SHALL take N+2 cycles.
REQ-028 start SHALL be ignored outside IDLE.
REQ-029 The maximum length SHALL be 2^LEN_WIDTH-1, and the counter SHALL NOT wrap within a run.

Reset
REQ-030 rst_in=1 at any clock edge SHALL force IDLE, clear the counter and the pending flag, and drive all outputs to 0, including mid-run and while in LAST.
REQ-031 Reset SHALL take priority over start, abort and result_ready.

Configuration
REQ-032 With MAC_SEQ_ABORT_EN defined, the abort port SHALL exist.
- abort=1 in RUN or LAST: return to IDLE next cycle, no result_valid, pending cleared, all MAC controls 0 in the abort cycle.
- abort has lower priority than rst_in.
REQ-033 Without MAC_SEQ_ABORT_EN, the abort port and its logic SHALL be absent, and behaviour SHALL be otherwise identical.

Structure
REQ-034 The shared package mac_pkg SHALL hold the state enum typedef (IDLE, RUN, LAST) and the default LEN_WIDTH constant.
REQ-035 The block SHALL be a single module with no sub-modules, verified in a bench that instantiates the existing mac.

Verification
REQ-036 Scenario: len=4, operand pairs (1,2), (3,4), (5,6), (7,8) with no bubbles, result_ready=1 -> result_valid for 1 cycle with out=100; busy high for 6 cycles.
REQ-037 Scenario: len=3, same operands as the first three pairs, with op_valid low 2 cycles between each pair -> out=44.
REQ-038 Scenario: len=1, operands (-3,5) -> mac_accumulate=0 in LAST and out=-15.
REQ-039 Scenario: len=2 with result_ready held low 5 cycles -> result_valid and out=11 stable for 6 cycles, then IDLE.
REQ-040 Scenario: start with len=0 -> a 1-cycle len_err pulse and no change to busy.
REQ-041 Scenario: rst_in high for 1 cycle after 2 of 4 accepts, then a new len=2 run -> all outputs 0 after reset, then correct out=11.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared definitions for the MAC sequencer: state encoding and default length width.
package mac_pkg;

    localparam int unsigned LEN_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        LAST
    } seq_state_t;

endpackage

// File: rtl/mac_sequencer.sv
// Sequences operand pairs into an external MAC to form a dot product of length len.
// Optional abort port and logic are built only when MAC_SEQ_ABORT_EN is defined.
module mac_sequencer #(
    parameter int unsigned LEN_WIDTH = mac_pkg::LEN_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_in,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] len,
    input  logic                 op_valid,
    output logic                 op_ready,
    output logic                 mac_p_valid,
    output logic                 mac_input_valid,
    output logic                 mac_accumulate,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic                 busy,
`ifdef MAC_SEQ_ABORT_EN
    input  logic                 abort,
`endif
    output logic                 len_err
);

    import mac_pkg::*;

    localparam logic [LEN_WIDTH-1:0] ONE = LEN_WIDTH'(1);

    seq_state_t           state;
    seq_state_t           state_nxt;
    logic [LEN_WIDTH-1:0] len_q;
    logic [LEN_WIDTH-1:0] cnt;
    logic                 pending;
    logic                 len_err_q;
    logic                 accept;
    logic                 abort_req;

`ifdef MAC_SEQ_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    always_comb begin
        state_nxt       = state;
        op_ready        = 1'b0;
        mac_p_valid     = 1'b0;
        mac_input_valid = 1'b0;
        mac_accumulate  = 1'b0;
        result_valid    = 1'b0;
        accept          = 1'b0;
        busy            = (state != IDLE);
        len_err         = len_err_q;

        case (state)
            IDLE: begin
                if (start && (len != '0)) state_nxt = RUN;
            end
            RUN: begin
                if (abort_req) begin
                    state_nxt = IDLE;
                end else begin
                    op_ready        = 1'b1;
                    accept          = op_valid;
                    mac_p_valid     = op_valid;
                    // The pending product has index cnt-1; only index 0 starts a fresh sum.
                    mac_input_valid = pending;
                    mac_accumulate  = pending && (cnt != ONE);
                    if (op_valid && (cnt == len_q - ONE)) state_nxt = LAST;
                end
            end
            LAST: begin
                if (abort_req) begin
                    state_nxt = IDLE;
                end else begin
                    result_valid   = 1'b1;
                    mac_accumulate = (len_q != ONE);
                    if (result_ready) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Outputs are held low for the whole reset cycle, not just after it.
        if (rst_in) begin
            state_nxt       = IDLE;
            op_ready        = 1'b0;
            mac_p_valid     = 1'b0;
            mac_input_valid = 1'b0;
            mac_accumulate  = 1'b0;
            result_valid    = 1'b0;
            accept          = 1'b0;
            busy            = 1'b0;
            len_err         = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            state     <= IDLE;
            len_q     <= '0;
            cnt       <= '0;
            pending   <= 1'b0;
            len_err_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            len_err_q <= (state == IDLE) && start && (len == '0);
            case (state)
                IDLE: begin
                    if (start && (len != '0)) begin
                        len_q   <= len;
                        cnt     <= '0;
                        pending <= 1'b0;
                    end
                end
                RUN: begin
                    if (abort_req) begin
                        pending <= 1'b0;
                    end else begin
                        if (accept) cnt <= cnt + ONE;
                        pending <= accept;
                    end
                end
                LAST: begin
                    if (abort_req || result_ready) pending <= 1'b0;
                end
                default: pending <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_sequencer.sv
// Self-checking bench for mac_sequencer driving a behavioural MAC (product register + accumulator).
module tb_mac_sequencer;

    localparam int unsigned LW = 8;

    logic          clk = 1'b0;
    logic          rst_in;
    logic          start;
    logic [LW-1:0] len;
    logic          op_valid;
    logic          op_ready;
    logic          mac_p_valid;
    logic          mac_input_valid;
    logic          mac_accumulate;
    logic          result_valid;
    logic          result_ready;
    logic          busy;
    logic          abort;
    logic          len_err;

    int a_in, b_in;
    int p_reg, acc, mac_out;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mac_sequencer #(.LEN_WIDTH(LW)) dut (
        .clk             (clk),
        .rst_in          (rst_in),
        .start           (start),
        .len             (len),
        .op_valid        (op_valid),
        .op_ready        (op_ready),
        .mac_p_valid     (mac_p_valid),
        .mac_input_valid (mac_input_valid),
        .mac_accumulate  (mac_accumulate),
        .result_valid    (result_valid),
        .result_ready    (result_ready),
        .busy            (busy),
`ifdef MAC_SEQ_ABORT_EN
        .abort           (abort),
`endif
        .len_err         (len_err)
    );

    // Behavioural MAC: product register, accumulator, combinational sum on out.
    always_ff @(posedge clk) begin
        if (mac_p_valid) p_reg <= a_in * b_in;
        if (mac_input_valid) acc <= mac_accumulate ? acc + p_reg : p_reg;
    end
    assign mac_out = mac_accumulate ? acc + p_reg : p_reg;

    // ctl bit order: {op_ready, p_valid, input_valid, accumulate, result_valid, busy, len_err}
    typedef struct {
        logic       rst;
        logic       start;
        logic [7:0] len;
        logic       opv;
        int         a;
        int         b;
        logic       rr;
        logic [6:0] exp_ctl;
        logic       chk;
        int         exp_out;
    } vec_t;

    function automatic vec_t mk(input bit r, input bit st, input int l, input bit ov,
                                input int a, input int b, input bit rr,
                                input bit [6:0] c, input bit chk, input int o);
        vec_t v;
        v.rst = r; v.start = st; v.len = l[7:0]; v.opv = ov; v.a = a; v.b = b; v.rr = rr;
        v.exp_ctl = c; v.chk = chk; v.exp_out = o;
        return v;
    endfunction

    task automatic apply(input vec_t v, input string name);
        logic [6:0] got;
        rst_in = v.rst; start = v.start; len = v.len; op_valid = v.opv;
        a_in = v.a; b_in = v.b; result_ready = v.rr;
        @(negedge clk);
        got = {op_ready, mac_p_valid, mac_input_valid, mac_accumulate, result_valid, busy, len_err};
        n_vec++;
        if ((got !== v.exp_ctl) || (v.chk && (mac_out !== v.exp_out))) begin
            n_err++;
            $display("FAIL %s: ctl=%b out=%0d, expected ctl=%b out=%0d%s", name, got, mac_out,
                     v.exp_ctl, v.exp_out, v.chk ? "" : " (out unchecked)");
        end
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[$];

    initial begin
        rst_in = 1'b1; start = 1'b0; len = '0; op_valid = 1'b0; result_ready = 1'b0;
        abort = 1'b0; a_in = 0; b_in = 0;

        // Reset beats start/result_ready; then len=4 no bubbles (sum 100), len=3 with bubbles (44), len=1 (-15).
        tbl.push_back(mk(1, 1, 4, 1, 1, 2, 1, 7'b0000000, 0, 0));
        tbl.push_back(mk(1, 1, 4, 1, 1, 2, 1, 7'b0000000, 0, 0));
        tbl.push_back(mk(0, 1, 4, 0, 0, 0, 0, 7'b0000000, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 2, 0, 7'b1100010, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 3, 4, 0, 7'b1110010, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 5, 6, 0, 7'b1111010, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 7, 8, 0, 7'b1111010, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 7'b0001110, 1, 100));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 7'b0000000, 0, 0));
        tbl.push_back(mk(0, 1, 3, 0, 0, 0, 0, 7'b0000000, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 2, 0, 7'b1100010, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 7'b1010010, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 7'b1000010, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 3, 4, 0, 7'b1100010, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 7'b1011010, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 7'b1000010, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 5, 6, 0, 7'b1100010, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 7'b0001110, 1, 44));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 7'b0000000, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 7'b0000000, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, -3, 5, 0, 7'b1100010, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 7'b0000110, 1, -15));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 7'b0000000, 0, 0));

        @(posedge clk);
        #1;
        foreach (tbl[i]) apply(tbl[i], $sformatf("table[%0d]", i));

        // len=2 with result held off for 5 cycles: result and sum stay put for 6 cycles.
        apply(mk(0, 1, 2, 0, 0, 0, 0, 7'b0000000, 0, 0), "hold_start");
        apply(mk(0, 0, 0, 1, 1, 2, 0, 7'b1100010, 0, 0), "hold_op0");
        apply(mk(0, 0, 0, 1, 3, 3, 0, 7'b1110010, 0, 0), "hold_op1");
        for (int i = 0; i < 5; i++)
            apply(mk(0, 1, 3, 0, 0, 0, 0, 7'b0001110, 1, 11), $sformatf("hold_wait%0d", i));
        apply(mk(0, 0, 0, 0, 0, 0, 1, 7'b0001110, 1, 11), "hold_take");
        apply(mk(0, 0, 0, 0, 0, 0, 0, 7'b0000000, 0, 0), "hold_idle");

        // Zero length: registered one-cycle len_err, busy never rises.
        apply(mk(0, 1, 0, 0, 0, 0, 0, 7'b0000000, 0, 0), "len0_start");
        apply(mk(0, 0, 0, 0, 0, 0, 0, 7'b0000001, 0, 0), "len0_pulse");
        apply(mk(0, 0, 0, 0, 0, 0, 0, 7'b0000000, 0, 0), "len0_after");

        // Reset mid-run after two accepts, then a clean len=2 run.
        apply(mk(0, 1, 4, 0, 0, 0, 0, 7'b0000000, 0, 0), "rst_start");
        apply(mk(0, 0, 0, 1, 1, 2, 0, 7'b1100010, 0, 0), "rst_op0");
        apply(mk(0, 0, 0, 1, 3, 4, 0, 7'b1110010, 0, 0), "rst_op1");
        apply(mk(1, 1, 2, 1, 5, 6, 1, 7'b0000000, 0, 0), "rst_pulse");
        apply(mk(0, 0, 0, 1, 5, 6, 1, 7'b0000000, 0, 0), "rst_idle");
        apply(mk(0, 1, 2, 0, 0, 0, 0, 7'b0000000, 0, 0), "rerun_start");
        apply(mk(0, 0, 0, 1, 1, 2, 0, 7'b1100010, 0, 0), "rerun_op0");
        apply(mk(0, 0, 0, 1, 3, 3, 0, 7'b1110010, 0, 0), "rerun_op1");
        apply(mk(0, 0, 0, 0, 0, 0, 1, 7'b0001110, 1, 11), "rerun_last");
        apply(mk(0, 0, 0, 0, 0, 0, 0, 7'b0000000, 0, 0), "rerun_idle");

`ifdef MAC_SEQ_ABORT_EN
        // Abort in RUN and in LAST: controls low in the abort cycle, back to IDLE without a result.
        apply(mk(0, 1, 3, 0, 0, 0, 0, 7'b0000000, 0, 0), "abort_run_start");
        apply(mk(0, 0, 0, 1, 1, 2, 0, 7'b1100010, 0, 0), "abort_run_op0");
        abort = 1'b1;
        apply(mk(0, 0, 0, 1, 3, 4, 0, 7'b0000010, 0, 0), "abort_run_cycle");
        abort = 1'b0;
        apply(mk(0, 0, 0, 1, 3, 4, 0, 7'b0000000, 0, 0), "abort_run_idle");
        apply(mk(0, 1, 1, 0, 0, 0, 0, 7'b0000000, 0, 0), "abort_last_start");
        apply(mk(0, 0, 0, 1, 2, 2, 0, 7'b1100010, 0, 0), "abort_last_op0");
        abort = 1'b1;
        apply(mk(0, 0, 0, 0, 0, 0, 0, 7'b0000010, 0, 0), "abort_last_cycle");
        abort = 1'b0;
        apply(mk(0, 0, 0, 0, 0, 0, 0, 7'b0000000, 0, 0), "abort_last_idle");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
